// File: rtl/rgb_matrix_pkg.sv
// Shared constants for the RGB matrix colour engine: mode and FSM encodings,
// hue-wheel segment codes and hue range helpers.
package rgb_matrix_pkg;

    // Button-selected display modes
    localparam logic [1:0] MODE_SOLID   = 2'd0;
    localparam logic [1:0] MODE_WHEEL   = 2'd1;
    localparam logic [1:0] MODE_RAINBOW = 2'd2;
    localparam logic [1:0] MODE_OFF     = 2'd3;

    // Update engine states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Hue wheel segments (hue >> PWM_BITS)
    localparam logic [2:0] SEG_RY = 3'd0;  // red -> yellow
    localparam logic [2:0] SEG_YG = 3'd1;  // yellow -> green
    localparam logic [2:0] SEG_GC = 3'd2;  // green -> cyan
    localparam logic [2:0] SEG_CB = 3'd3;  // cyan -> blue
    localparam logic [2:0] SEG_BM = 3'd4;  // blue -> magenta
    localparam logic [2:0] SEG_MR = 3'd5;  // magenta -> red

    // Number of distinct hues: six segments of 2^pwm_bits steps each
    function automatic int hue_range(input int pwm_bits);
        return 6 * (2 ** pwm_bits);
    endfunction

    // Width of the hue register: segment index (3 bits) above the fraction
    function automatic int hue_width(input int pwm_bits);
        return pwm_bits + 3;
    endfunction

endpackage

// File: rtl/rgb_matrix_color_engine_hue_color.sv
// Combinational hue-to-colour conversion followed by brightness scaling.
// The scaled product is truncated (no rounding).
module rgb_hue_color
    import rgb_matrix_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic [PWM_BITS+2:0] i_hue,
    input  logic [PWM_BITS-1:0] i_bright,
    output logic [PWM_BITS-1:0] o_r,
    output logic [PWM_BITS-1:0] o_g,
    output logic [PWM_BITS-1:0] o_b
);

    localparam logic [PWM_BITS-1:0] MAX = '1;

    logic [2:0]          w_seg;
    logic [PWM_BITS-1:0] w_f;
    logic [PWM_BITS-1:0] w_c_r;
    logic [PWM_BITS-1:0] w_c_g;
    logic [PWM_BITS-1:0] w_c_b;

    assign w_seg = i_hue[PWM_BITS+2:PWM_BITS];
    assign w_f   = i_hue[PWM_BITS-1:0];

    function automatic logic [PWM_BITS-1:0] scale(input logic [PWM_BITS-1:0] c,
                                                  input logic [PWM_BITS-1:0] b);
        logic [2*PWM_BITS-1:0] p;
        p = {{PWM_BITS{1'b0}}, c} * {{PWM_BITS{1'b0}}, b};
        return p[2*PWM_BITS-1:PWM_BITS];
    endfunction

    // Piecewise-linear hue wheel: one channel ramps while the others sit at 0 or MAX
    always_comb begin
        w_c_r = '0;
        w_c_g = '0;
        w_c_b = '0;
        case (w_seg)
            SEG_RY: begin w_c_r = MAX;       w_c_g = w_f;        end
            SEG_YG: begin w_c_r = MAX - w_f; w_c_g = MAX;        end
            SEG_GC: begin w_c_g = MAX;       w_c_b = w_f;        end
            SEG_CB: begin w_c_g = MAX - w_f; w_c_b = MAX;        end
            SEG_BM: begin w_c_r = w_f;       w_c_b = MAX;        end
            SEG_MR: begin w_c_r = MAX;       w_c_b = MAX - w_f;  end
            default: ;
        endcase
    end

    assign o_r = scale(w_c_r, i_bright);
    assign o_g = scale(w_c_g, i_bright);
    assign o_b = scale(w_c_b, i_bright);

endmodule

// File: rtl/rgb_matrix_color_engine.sv
// RGB LED matrix colour engine: PWM timebase, hue/mode state, a one-LED-per-cycle
// update engine filling a shadow duty bank, and a frame-synchronous swap into
// the active bank that drives the registered PWM comparators.
module rgb_matrix_color_engine
    import rgb_matrix_pkg::*;
#(
    parameter int N_LED        = 25,
    parameter int PWM_BITS     = 8,
    parameter int CLK_DIV      = 16,
    parameter int STEP_FRAMES  = 4,
    parameter int LED_HUE_STEP = 61
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                btn_edge,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [N_LED-1:0]    R,
    output logic [N_LED-1:0]    G,
    output logic [N_LED-1:0]    B,
    output logic [1:0]          mode,
    output logic                frame_tick
);

    localparam int HUE_W = hue_width(PWM_BITS);
    localparam int HR    = hue_range(PWM_BITS);
    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FC_W  = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam int IDX_W = (N_LED > 1) ? $clog2(N_LED) : 1;

    localparam logic [PWM_BITS-1:0] MAX      = '1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [FC_W-1:0]     FC_LAST  = FC_W'(STEP_FRAMES - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_LED - 1);
    localparam logic [HUE_W-1:0]    HUE_LAST = HUE_W'(HR - 1);
    localparam logic [HUE_W:0]      HR_X     = (HUE_W + 1)'(HR);
    localparam logic [HUE_W:0]      STEP_X   = (HUE_W + 1)'(LED_HUE_STEP % HR);

    logic [PRE_W-1:0]    r_presc;
    logic [PWM_BITS-1:0] r_pwm;
    logic [FC_W-1:0]     r_fc;
    logic [HUE_W-1:0]    r_hue;
    logic [1:0]          r_mode;
    logic [1:0]          r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [1:0]          r_calc_mode;
    logic [PWM_BITS-1:0] r_calc_bright;
    logic [HUE_W-1:0]    r_acc;

    logic [PWM_BITS-1:0] r_sh_r  [N_LED];
    logic [PWM_BITS-1:0] r_sh_g  [N_LED];
    logic [PWM_BITS-1:0] r_sh_b  [N_LED];
    logic [PWM_BITS-1:0] r_act_r [N_LED];
    logic [PWM_BITS-1:0] r_act_g [N_LED];
    logic [PWM_BITS-1:0] r_act_b [N_LED];

    logic                w_presc_wrap;
    logic                w_frame_wrap;
    logic                w_calc_we;
    logic                w_swap;
    logic [HUE_W:0]      w_acc_sum;
    logic [HUE_W-1:0]    w_acc_next;
    logic [PWM_BITS-1:0] w_col_r;
    logic [PWM_BITS-1:0] w_col_g;
    logic [PWM_BITS-1:0] w_col_b;
    logic [PWM_BITS-1:0] w_duty_r;
    logic [PWM_BITS-1:0] w_duty_g;
    logic [PWM_BITS-1:0] w_duty_b;

    // Frame boundary: last PWM step of the frame at a prescaler wrap. Decoded
    // from registers only, so it is a clean single-cycle pulse.
    assign w_presc_wrap = (r_presc == PRE_LAST);
    assign w_frame_wrap = w_presc_wrap && (r_pwm == MAX);
    assign frame_tick   = w_frame_wrap;
    assign mode         = r_mode;

    assign w_calc_we = (r_state == ST_CALC);
    assign w_swap    = (r_state == ST_DONE) && w_frame_wrap;

    // Incremental per-LED hue for RAINBOW, reduced modulo HR without a divider
    assign w_acc_sum  = {1'b0, r_acc} + STEP_X;
    assign w_acc_next = HUE_W'((w_acc_sum >= HR_X) ? (w_acc_sum - HR_X) : w_acc_sum);

    rgb_hue_color #(
        .PWM_BITS (PWM_BITS)
    ) u_hue_color (
        .i_hue    (r_acc),
        .i_bright (r_calc_bright),
        .o_r      (w_col_r),
        .o_g      (w_col_g),
        .o_b      (w_col_b)
    );

    assign w_duty_r = (r_calc_mode == MODE_OFF) ? '0 : w_col_r;
    assign w_duty_g = (r_calc_mode == MODE_OFF) ? '0 : w_col_g;
    assign w_duty_b = (r_calc_mode == MODE_OFF) ? '0 : w_col_b;

    // PWM timebase: prescaler divides clk, PWM counter steps once per prescaler wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
            r_pwm   <= '0;
        end else if (w_presc_wrap) begin
            r_presc <= '0;
            r_pwm   <= r_pwm + PWM_BITS'(1);
        end else begin
            r_presc <= r_presc + PRE_W'(1);
        end
    end

    // Frame counter and hue: hue advances every STEP_FRAMES frames in WHEEL/RAINBOW
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fc  <= '0;
            r_hue <= '0;
        end else if (w_frame_wrap) begin
            if (r_fc == FC_LAST) begin
                r_fc <= '0;
                if (r_mode == MODE_WHEEL || r_mode == MODE_RAINBOW) begin
                    r_hue <= (r_hue == HUE_LAST) ? '0 : r_hue + HUE_W'(1);
                end
            end else begin
                r_fc <= r_fc + FC_W'(1);
            end
        end
    end

    // Mode register: each button pulse advances the mode, wrapping OFF -> SOLID
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode <= MODE_SOLID;
        end else if (btn_edge) begin
            r_mode <= r_mode + 2'd1;
        end
    end

    // Update engine: latch frame inputs at the tick, then compute one LED per cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_calc_mode   <= MODE_SOLID;
            r_calc_bright <= '0;
            r_acc         <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_frame_wrap) begin
                        r_state       <= ST_CALC;
                        r_idx         <= '0;
                        r_calc_mode   <= r_mode;
                        r_calc_bright <= brightness;
                        r_acc         <= r_hue;
                    end
                end
                ST_CALC: begin
                    if (r_calc_mode == MODE_RAINBOW) begin
                        r_acc <= w_acc_next;
                    end
                    if (r_idx == IDX_LAST) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Duty banks: shadow written during CALC, copied to active only at a frame boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_LED; i++) begin
                r_sh_r[i]  <= '0;
                r_sh_g[i]  <= '0;
                r_sh_b[i]  <= '0;
                r_act_r[i] <= '0;
                r_act_g[i] <= '0;
                r_act_b[i] <= '0;
            end
        end else begin
            if (w_calc_we) begin
                r_sh_r[r_idx] <= w_duty_r;
                r_sh_g[r_idx] <= w_duty_g;
                r_sh_b[r_idx] <= w_duty_b;
            end
            if (w_swap) begin
                for (int i = 0; i < N_LED; i++) begin
                    r_act_r[i] <= r_sh_r[i];
                    r_act_g[i] <= r_sh_g[i];
                    r_act_b[i] <= r_sh_b[i];
                end
            end
        end
    end

    // Registered PWM comparators driving the matrix pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            R <= '0;
            G <= '0;
            B <= '0;
        end else begin
            for (int i = 0; i < N_LED; i++) begin
                R[i] <= (r_pwm < r_act_r[i]);
                G[i] <= (r_pwm < r_act_g[i]);
                B[i] <= (r_pwm < r_act_b[i]);
            end
        end
    end

endmodule

// File: tb/tb_rgb_matrix_color_engine.sv
// Self-checking bench for rgb_matrix_color_engine. A frame-level reference model
// (hue wheel arithmetic, double-buffered frame parameters) predicts the number
// of high cycles per LED and colour in every PWM frame.
module tb_rgb_matrix_color_engine;

    localparam int N     = 4;
    localparam int PB    = 4;
    localparam int CD    = 1;
    localparam int SF    = 2;
    localparam int STEP  = 16;
    localparam int MAXV  = 15;
    localparam int HRV   = 96;
    localparam int FRAME = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          btn_edge;
    logic [PB-1:0] brightness;
    logic [N-1:0]  R;
    logic [N-1:0]  G;
    logic [N-1:0]  B;
    logic [1:0]    mode;
    logic          frame_tick;

    rgb_matrix_color_engine #(
        .N_LED        (N),
        .PWM_BITS     (PB),
        .CLK_DIV      (CD),
        .STEP_FRAMES  (SF),
        .LED_HUE_STEP (STEP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_edge   (btn_edge),
        .brightness (brightness),
        .R          (R),
        .G          (G),
        .B          (B),
        .mode       (mode),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_mode, m_hue, m_fc;
    bit sh_valid, disp_valid;
    int sh_mode, sh_bright, sh_hue;
    int disp_mode, disp_bright, disp_hue;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_duty(input int md, input int br, input int hue0,
                                      input int led, input int comp);
        int h, seg, f;
        int rgb[3];
        if (md == 3) return 0;
        h   = (md == 2) ? (hue0 + led * STEP) % HRV : hue0;
        seg = h / (MAXV + 1);
        f   = h % (MAXV + 1);
        case (seg)
            0:       rgb = '{MAXV, f, 0};
            1:       rgb = '{MAXV - f, MAXV, 0};
            2:       rgb = '{0, MAXV, f};
            3:       rgb = '{0, MAXV - f, MAXV};
            4:       rgb = '{f, 0, MAXV};
            default: rgb = '{MAXV, 0, MAXV - f};
        endcase
        return (rgb[comp] * br) / (MAXV + 1);
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_hue = 0; m_fc = 0;
        sh_valid = 0; disp_valid = 0;
        sh_mode = 0; sh_bright = 0; sh_hue = 0;
        disp_mode = 0; disp_bright = 0; disp_hue = 0;
    endfunction

    // Frame boundary: previously computed frame goes live, new inputs are captured
    function automatic void model_tick();
        if (sh_valid) begin
            disp_mode = sh_mode; disp_bright = sh_bright; disp_hue = sh_hue;
            disp_valid = 1;
        end
        sh_mode = m_mode; sh_bright = int'(brightness); sh_hue = m_hue;
        sh_valid = 1;
        if (m_fc == SF - 1) begin
            m_fc = 0;
            if (m_mode == 1 || m_mode == 2) m_hue = (m_hue + 1) % HRV;
        end else begin
            m_fc++;
        end
    endfunction

    task automatic check_dark(input string tag);
        check_val({tag, "_R"}, int'(R), 0);
        check_val({tag, "_G"}, int'(G), 0);
        check_val({tag, "_B"}, int'(B), 0);
        check_val({tag, "_mode"}, int'(mode), 0);
        check_val({tag, "_tick"}, int'(frame_tick), 0);
    endtask

    // After reset release: outputs dark until the first tick, tick after FRAME-1 cycles
    task automatic sync_first();
        int waited = 0;
        bit found  = 0;
        bit dark_bad = 0;
        while (!found && waited < 4 * FRAME) begin
            @(negedge clk);
            waited++;
            if (frame_tick) found = 1;
            else if (R != 0 || G != 0 || B != 0) dark_bad = 1;
        end
        check_val("first_tick_seen", int'(found), 1);
        check_val("first_tick_cycle", waited, FRAME - 1);
        check_val("dark_before_first_tick", int'(dark_bad), 0);
        model_tick();
        @(posedge clk);
    endtask

    // One PWM frame: count high cycles per pin, optionally press the button
    // n_press times (every other cycle from press_k) and change brightness at bright_k
    task automatic measure_frame(input int n_press, input int press_k,
                                 input int new_bright, input int bright_k);
        int exp_c[N][3];
        int cnt[N][3];
        int ticks = 0;
        int tick_pos = -1;
        for (int i = 0; i < N; i++)
            for (int c = 0; c < 3; c++) begin
                exp_c[i][c] = disp_valid ? model_duty(disp_mode, disp_bright, disp_hue, i, c) : 0;
                cnt[i][c] = 0;
            end
        for (int k = 0; k < FRAME; k++) begin
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                cnt[i][0] += int'(R[i]);
                cnt[i][1] += int'(G[i]);
                cnt[i][2] += int'(B[i]);
            end
            if (frame_tick) begin
                ticks++;
                tick_pos = k;
            end
            btn_edge = 1'b0;
            if (k == FRAME - 2) model_tick();
            if (n_press > 0 && k >= press_k && k <= press_k + 2 * (n_press - 1)
                && ((k - press_k) % 2 == 0)) begin
                btn_edge = 1'b1;
                m_mode = (m_mode + 1) % 4;
            end
            if (k == bright_k) brightness = PB'(new_bright);
        end
        check_val("ticks_per_frame", ticks, 1);
        check_val("tick_position", tick_pos, FRAME - 2);
        check_val("mode", int'(mode), m_mode);
        for (int i = 0; i < N; i++) begin
            check_val($sformatf("R%0d_high_cycles", i), cnt[i][0], exp_c[i][0]);
            check_val($sformatf("G%0d_high_cycles", i), cnt[i][1], exp_c[i][1]);
            check_val($sformatf("B%0d_high_cycles", i), cnt[i][2], exp_c[i][2]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        btn_edge   = 1'b0;
        brightness = PB'(15);
        model_reset();
        repeat (3) @(negedge clk);
        check_dark("reset");
        reset_n = 1'b1;

        // Dark frame, then SOLID hue 0 at full brightness
        sync_first();
        measure_frame(0, 0, 15, -1);
        measure_frame(0, 0, 15, -1);

        // Brightness 8 takes effect one frame after it is sampled
        measure_frame(0, 0, 8, 6);
        measure_frame(0, 0, 8, -1);
        measure_frame(0, 0, 8, -1);

        // Three presses to OFF, then one press back to SOLID
        measure_frame(3, 2, 8, -1);
        measure_frame(0, 0, 8, -1);
        measure_frame(0, 0, 8, -1);
        measure_frame(1, 4, 15, 3);
        measure_frame(0, 0, 15, -1);

        // RAINBOW from hue 0
        measure_frame(2, 4, 15, -1);
        repeat (3) measure_frame(0, 0, 15, -1);

        // WHEEL long enough for the hue to pass 95 and wrap to 0
        measure_frame(3, 4, 15, -1);
        repeat (200) measure_frame(0, 0, 15, -1);

        // Press coincident with the frame tick
        measure_frame(1, FRAME - 2, 15, -1);
        repeat (2) measure_frame(0, 0, 15, -1);

        // Random presses and brightness changes
        for (int f = 0; f < 30; f++) begin
            measure_frame($urandom_range(0, 2), $urandom_range(0, 10),
                          $urandom_range(0, 15), $urandom_range(0, 13));
        end
        if (m_mode == 0 || m_mode == 3) measure_frame((m_mode == 0) ? 1 : 2, 3, 15, 2);
        else measure_frame(0, 0, 15, 2);
        measure_frame(0, 0, 15, -1);
        measure_frame(0, 0, 15, -1);

        // Reset while CALC is running
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_dark("mid_calc_reset");
        repeat (2) @(negedge clk);
        check_dark("mid_calc_reset_held");
        brightness = PB'(15);
        model_reset();
        reset_n = 1'b1;

        sync_first();
        measure_frame(0, 0, 15, -1);
        measure_frame(0, 0, 15, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
